// File: rtl/siso_shift_ctrl.sv
// Transaction controller for a free-running fixed-latency SISO delay chain:
// serialises a parallel word MSB-first and reassembles it as the bits emerge.
module siso_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int LAT   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             sr_din,
    input  logic             sr_dout,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy
);
    localparam int               CNT_W     = $clog2(WIDTH + LAT);
    localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(LAT + WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_tx_sh;
    logic [WIDTH-2:0] r_cap;
    logic             r_sr_din;
    logic             r_rx_valid;
    logic [WIDTH-1:0] r_rx_data;

    logic             w_cap_en;
    logic [WIDTH-1:0] w_cap_next;

    // Only the LAT..LAT+WIDTH-1 window of the chain output carries our bits.
    assign w_cap_en   = (r_cnt >= CAP_FIRST) && (r_cnt <= CAP_LAST);
    assign w_cap_next = {r_cap, sr_dout};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_tx_sh    <= '0;
            r_cap      <= '0;
            r_sr_din   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_state  <= RUN;
                        r_cnt    <= '0;
                        r_tx_sh  <= tx_data;
                        r_sr_din <= tx_data[WIDTH-1];
                    end else begin
                        r_sr_din <= 1'b0;
                    end
                end
                RUN: begin
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Shadow shifts left so zeros follow the last data bit.
                    r_tx_sh  <= r_tx_sh << 1;
                    r_sr_din <= r_tx_sh[WIDTH-2];
                    if (w_cap_en) begin
                        r_cap <= w_cap_next[WIDTH-2:0];
                    end
                    if (r_cnt == CAP_LAST) begin
                        r_rx_data  <= w_cap_next;
                        r_rx_valid <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_ready = (r_state == IDLE);
    assign busy     = (r_state == RUN);
    assign sr_din   = r_sr_din;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: three instances (LAT 5 default, 1, 12) each
// looped through a delay-chain model, checked against a scoreboard queue.
module tb_siso_shift_ctrl;
    localparam int NI = 3;

    function automatic int lat_of(input int g);
        return (g == 0) ? 5 : ((g == 1) ? 1 : 12);
    endfunction

    typedef struct {
        int         id;
        logic [7:0] data;
        int         acc;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       txv   [NI];
    logic [7:0] txd   [NI];
    logic       txr   [NI];
    logic       sdin  [NI];
    logic       sdout [NI];
    logic       rxv   [NI];
    logic [7:0] rxd   [NI];
    logic       bsy   [NI];
    logic       noise_en = 1'b0;
    logic       noise = 1'b0;

    sb_t sb[$];
    int  cyc = 0;
    int  acc_prev0 = -1;
    int  acc_last0 = -1;
    int  n_cmp = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [31:0] dl = '0;
        always @(posedge clk) dl <= {dl[30:0], sdin[g]};
        assign sdout[g] = noise_en ? noise : dl[lat_of(g)-1];
        if (g == 0) begin : g_def
            siso_shift_ctrl u_dut (
                .clk(clk), .reset_n(reset_n), .tx_valid(txv[g]), .tx_data(txd[g]),
                .tx_ready(txr[g]), .sr_din(sdin[g]), .sr_dout(sdout[g]),
                .rx_valid(rxv[g]), .rx_data(rxd[g]), .busy(bsy[g]));
        end else begin : g_par
            siso_shift_ctrl #(.WIDTH(8), .LAT(lat_of(g))) u_dut (
                .clk(clk), .reset_n(reset_n), .tx_valid(txv[g]), .tx_data(txd[g]),
                .tx_ready(txr[g]), .sr_din(sdin[g]), .sr_dout(sdout[g]),
                .rx_valid(rxv[g]), .rx_data(rxd[g]), .busy(bsy[g]));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pending(input int g);
        int n = 0;
        foreach (sb[k]) if (sb[k].id == g) n++;
        return n;
    endfunction

    // Push expected words at the accept edge; reset abandons everything in flight.
    always @(posedge clk) begin
        if (!reset_n) begin
            sb.delete();
        end else begin
            for (int g = 0; g < NI; g++) begin
                if (txv[g] === 1'b1 && txr[g] === 1'b1) begin
                    sb.push_back('{g, txd[g], cyc});
                    if (g == 0) begin
                        acc_prev0 = acc_last0;
                        acc_last0 = cyc;
                    end
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        int idx;
        for (int g = 0; g < NI; g++) begin
            if (rxv[g] === 1'b1) begin
                idx = -1;
                foreach (sb[k]) if (idx < 0 && sb[k].id == g) idx = k;
                chk($sformatf("rx_expected[%0d]", g), 32'(idx >= 0), 32'd1);
                if (idx >= 0) begin
                    chk($sformatf("rx_data[%0d]", g), 32'(rxd[g]), 32'(sb[idx].data));
                    chk($sformatf("latency[%0d]", g), 32'(cyc - sb[idx].acc),
                        32'(8 + lat_of(g) + 1));
                    sb.delete(idx);
                end
            end
        end
    end

    task automatic wait_accept(input int g);
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (txr[g] === 1'b1 && reset_n === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send(input int g, input logic [7:0] d);
        @(negedge clk);
        txv[g] = 1'b1;
        txd[g] = d;
        wait_accept(g);
        txv[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        int k = 0;
        while (pending(g) != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 32'(pending(g)), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_tx_ready"}, 32'(txr[0]), 32'd1);
        chk({tag, "_busy"}, 32'(bsy[0]), 32'd0);
        chk({tag, "_sr_din"}, 32'(sdin[0]), 32'd0);
        chk({tag, "_rx_valid"}, 32'(rxv[0]), 32'd0);
        chk({tag, "_rx_data"}, 32'(rxd[0]), 32'd0);
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] held;
        for (int g = 0; g < NI; g++) begin
            txv[g] = 1'b0;
            txd[g] = 8'h00;
        end

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_zero("reset");
        for (int g = 1; g < NI; g++) chk("reset_ready_par", 32'(txr[g]), 32'd1);
        reset_n = 1'b1;

        // 0xA5: serial drive order, then zeros
        w = 8'hA5;
        send(0, w);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i < 8) chk($sformatf("sr_din_e%0d", i), 32'(sdin[0]), 32'(w[7-i]));
            else       chk($sformatf("sr_din_e%0d", i), 32'(sdin[0]), 32'd0);
        end
        drain(0);

        // Back-to-back with tx_valid held: 0x3C then 0xFF
        @(negedge clk);
        txv[0] = 1'b1;
        txd[0] = 8'h3C;
        wait_accept(0);
        txd[0] = 8'hFF;
        wait_accept(0);
        txv[0] = 1'b0;
        chk("b2b_spacing", 32'(acc_last0 - acc_prev0), 32'd14);
        drain(0);

        // 0x81 with tx_data trashed during RUN
        send(0, 8'h81);
        txd[0] = 8'h00;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("run_ready_c%0d", i), 32'(txr[0]), 32'd0);
            chk($sformatf("run_busy_c%0d", i), 32'(bsy[0]), 32'd1);
        end
        @(negedge clk);
        chk("done_ready", 32'(txr[0]), 32'd1);
        chk("done_rx_valid", 32'(rxv[0]), 32'd1);
        drain(0);

        // Reset at E0+6 of 0x5A; a held tx_valid under reset must not be accepted
        send(0, 8'h5A);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        txv[0] = 1'b1;
        txd[0] = 8'h5A;
        @(negedge clk);
        chk_idle_zero("midrst");
        @(negedge clk);
        chk("rst_wins_ready", 32'(txr[0]), 32'd1);
        chk("rst_wins_pending", 32'(pending(0)), 32'd0);
        reset_n = 1'b1;
        txv[0] = 1'b0;
        send(0, 8'h96);
        drain(0);

        // Noise on the chain output while idle
        held = rxd[0];
        noise_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            noise = 1'($urandom);
            chk("noise_rx_valid", 32'(rxv[0]), 32'd0);
            chk("noise_rx_data", 32'(rxd[0]), 32'(held));
        end
        @(negedge clk);
        noise_en = 1'b0;
        noise = 1'b0;

        // LAT sweep: 1 and 12
        send(1, 8'hC3);
        drain(1);
        send(2, 8'hC3);
        drain(2);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
